// File: rtl/scene_ctrl.sv
// Scene sequencer for the VGA path: owns the scene select, changes it only at frame
// start (optionally blanking whole frames), and pulses a reset into the entered scene.
module scene_ctrl #(
  parameter int unsigned FADE_FRAMES    = 2,
  parameter int unsigned ENDGAME_FRAMES = 180,
  parameter bit          VS_ACTIVE_LOW  = 1'b1
) (
  input  logic       i_pclk,
  input  logic       i_rst,
  input  logic       i_vs,
  input  logic       i_start,
  input  logic       i_help,
  input  logic       i_back,
  input  logic       i_game_over,
  input  logic       i_winner,
  output logic [1:0] o_sel,
  output logic       o_blank,
  output logic       o_scene_rst,
  output logic       o_winner
);

  localparam logic [1:0] SCENE_MENU    = 2'b00;
  localparam logic [1:0] SCENE_BATTLE  = 2'b01;
  localparam logic [1:0] SCENE_ENDGAME = 2'b10;
  localparam logic [1:0] SCENE_HOWTO   = 2'b11;
  localparam logic [7:0] FADE_N        = 8'(FADE_FRAMES);
  localparam logic [7:0] ENDGAME_N     = 8'(ENDGAME_FRAMES);
  localparam logic       VS_IDLE       = VS_ACTIVE_LOW;

  typedef enum logic {ST_IDLE, ST_BLANK} state_t;

  state_t     state_reg, state_next;
  logic       vs_prev_reg;
  logic       fs_reg, fs_next;
  logic       pend_reg, pend_next;
  logic [1:0] target_reg, target_next;
  logic [1:0] sel_reg, sel_next;
  logic       blank_reg, blank_next;
  logic       scene_rst_reg, scene_rst_next;
  logic       winner_reg, winner_next;
  logic [7:0] fade_cnt_reg, fade_cnt_next;
  logic [7:0] eg_cnt_reg, eg_cnt_next;

  logic       req;
  logic [1:0] req_target;
  logic       take_winner;

  // Frame start is registered, so it lags the vsync edge on i_vs by one cycle.
  assign fs_next = (i_vs != VS_IDLE) && (vs_prev_reg == VS_IDLE);

  // Which event (if any) is a legal scene change from the current scene.
  always_comb begin
    req         = 1'b0;
    req_target  = SCENE_MENU;
    take_winner = 1'b0;
    case (sel_reg)
      SCENE_MENU: begin
        if (i_start) begin
          req        = 1'b1;
          req_target = SCENE_BATTLE;
        end else if (i_help) begin
          req        = 1'b1;
          req_target = SCENE_HOWTO;
        end
      end
      SCENE_HOWTO: begin
        if (i_back) begin
          req        = 1'b1;
          req_target = SCENE_MENU;
        end
      end
      SCENE_BATTLE: begin
        if (i_game_over) begin
          req         = 1'b1;
          req_target  = SCENE_ENDGAME;
          take_winner = 1'b1;
        end
      end
      default: begin
        if (i_start) begin
          req        = 1'b1;
          req_target = SCENE_BATTLE;
        end else if (i_back) begin
          req        = 1'b1;
          req_target = SCENE_MENU;
        end else if ((ENDGAME_FRAMES != 0) && (eg_cnt_reg == ENDGAME_N)) begin
          req        = 1'b1;
          req_target = SCENE_MENU;
        end
      end
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    pend_next      = pend_reg;
    target_next    = target_reg;
    sel_next       = sel_reg;
    blank_next     = blank_reg;
    scene_rst_next = 1'b0;
    winner_next    = winner_reg;
    fade_cnt_next  = fade_cnt_reg;
    eg_cnt_next    = eg_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (pend_reg) begin
          if (fs_reg) begin
            sel_next       = target_reg;
            scene_rst_next = 1'b1;
            pend_next      = 1'b0;
            if (target_reg == SCENE_ENDGAME) eg_cnt_next = 8'd0;
            if (FADE_FRAMES != 0) begin
              blank_next    = 1'b1;
              fade_cnt_next = FADE_N;
              state_next    = ST_BLANK;
            end
          end
        end else begin
          if (req) begin
            pend_next   = 1'b1;
            target_next = req_target;
            if (take_winner) winner_next = i_winner;
          end
          // Timeout counter saturates rather than wrapping when the timeout is disabled.
          if (fs_reg && (sel_reg == SCENE_ENDGAME) && (eg_cnt_reg != 8'hFF))
            eg_cnt_next = eg_cnt_reg + 8'd1;
        end
      end
      ST_BLANK: begin
        if (fs_reg) begin
          if (fade_cnt_reg <= 8'd1) begin
            fade_cnt_next = 8'd0;
            blank_next    = 1'b0;
            state_next    = ST_IDLE;
          end else begin
            fade_cnt_next = fade_cnt_reg - 8'd1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      state_reg     <= ST_IDLE;
      vs_prev_reg   <= VS_IDLE;
      fs_reg        <= 1'b0;
      pend_reg      <= 1'b0;
      target_reg    <= SCENE_MENU;
      sel_reg       <= SCENE_MENU;
      blank_reg     <= 1'b0;
      scene_rst_reg <= 1'b0;
      winner_reg    <= 1'b0;
      fade_cnt_reg  <= 8'd0;
      eg_cnt_reg    <= 8'd0;
    end else begin
      state_reg     <= state_next;
      vs_prev_reg   <= i_vs;
      fs_reg        <= fs_next;
      pend_reg      <= pend_next;
      target_reg    <= target_next;
      sel_reg       <= sel_next;
      blank_reg     <= blank_next;
      scene_rst_reg <= scene_rst_next;
      winner_reg    <= winner_next;
      fade_cnt_reg  <= fade_cnt_next;
      eg_cnt_reg    <= eg_cnt_next;
    end
  end

  assign o_sel       = sel_reg;
  assign o_blank     = blank_reg;
  assign o_scene_rst = scene_rst_reg;
  assign o_winner    = winner_reg;

endmodule
